// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C read master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        AACK,
        RXB,
        MACK,
        STOP
    } i2c_mst_state_t;

    localparam logic I2C_READ = 1'b1;
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_qtr_timer.sv
// Quarter bit-period timer: counts QTR_CYCLES clocks per quarter and tracks the quarter index.
module i2c_qtr_timer #(
    parameter int QTR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       qtr_last,
    output logic [1:0] qtr_idx
);

    localparam int CW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(QTR_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign qtr_last = en && (cnt == LAST);

    // Held at zero while idle so every transaction starts on a clean Q0.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt     <= '0;
            qtr_idx <= 2'd0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            qtr_idx <= qtr_idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_read_master.sv
// I2C read master: START, address+R, address ACK check, N byte reads with ACK/NACK, STOP.
module i2c_read_master
    import i2c_pkg::*;
#(
    parameter int QTR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_start,
    input  logic [6:0] slave_addr,
    input  logic [7:0] num_bytes,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       nack_err
);

    i2c_mst_state_t state, state_d;

    logic       qtr_last;
    logic [1:0] qtr_idx;
    logic       bit_end;
    logic       accept;
    logic       q1_bit;
    logic [7:0] tx_byte;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] remaining;

    i2c_qtr_timer #(
        .QTR_CYCLES(QTR_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (busy),
        .qtr_last(qtr_last),
        .qtr_idx (qtr_idx)
    );

    assign bit_end = qtr_last && (qtr_idx == 2'd3);

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        q1_bit  = 1'b1;
        case (state)
            IDLE: begin
                // A request landing in the done cycle is dropped on purpose.
                accept = cmd_start && !done;
                if (accept) state_d = START;
            end
            START: if (bit_end) state_d = ADDR;
            ADDR: begin
                q1_bit = tx_byte[bit_cnt];
                if (bit_end && bit_cnt == 3'd0) state_d = AACK;
            end
            AACK: begin
                if (bit_end) begin
                    if (sda_in == I2C_NACK || remaining == 8'd0) state_d = STOP;
                    else state_d = RXB;
                end
            end
            RXB: if (bit_end && bit_cnt == 3'd0) state_d = MACK;
            MACK: begin
                q1_bit = (remaining != 8'd0) ? I2C_ACK : I2C_NACK;
                if (bit_end) state_d = (remaining != 8'd0) ? RXB : STOP;
            end
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            scl_out   <= 1'b1;
            sda_out   <= 1'b1;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nack_err  <= 1'b0;
            tx_byte   <= 8'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            remaining <= 8'd0;
        end else begin
            state    <= state_d;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            if (accept) begin
                busy      <= 1'b1;
                nack_err  <= 1'b0;
                tx_byte   <= {slave_addr, I2C_READ};
                remaining <= num_bytes;
                scl_out   <= 1'b1;
                sda_out   <= 1'b1;
            end else if (busy && qtr_last) begin
                // Line updates happen on quarter boundaries only; SDA moves while SCL is low.
                case (qtr_idx)
                    2'd0: if (state != START && state != STOP) sda_out <= q1_bit;
                    2'd1: begin
                        if (state == START) sda_out <= 1'b0;
                        else scl_out <= 1'b1;
                    end
                    2'd2: if (state == STOP) sda_out <= 1'b1;
                    default: begin
                        scl_out <= (state == STOP);
                        bit_cnt <= (state == ADDR || state == RXB) ? bit_cnt - 3'd1 : 3'd7;
                        if (state == STOP) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else if (state_d == STOP) begin
                            sda_out <= 1'b0;
                        end
                        if (state == AACK && sda_in == I2C_NACK) nack_err <= 1'b1;
                        if (state == RXB) begin
                            shreg <= {shreg[5:0], sda_in};
                            if (bit_cnt == 3'd0) begin
                                rx_data   <= {shreg, sda_in};
                                rx_valid  <= 1'b1;
                                remaining <= remaining - 8'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_read_master.sv
// Bench for i2c_read_master: wired-AND bus with a behavioural slave and a transaction-level model.
module tb_i2c_read_master;

  localparam int Q   = 4;
  localparam int BIT = 4 * Q;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_start;
  logic [6:0] slave_addr;
  logic [7:0] num_bytes;
  logic       scl_out, sda_out, rx_valid, busy, done, nack_err;
  logic [7:0] rx_data;
  logic       slave_drive;
  logic       sda_bus;

  assign sda_bus = sda_out & slave_drive;

  i2c_read_master #(.QTR_CYCLES(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_start (cmd_start),
    .slave_addr(slave_addr),
    .num_bytes (num_bytes),
    .sda_in    (sda_bus),
    .scl_out   (scl_out),
    .sda_out   (sda_out),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .done      (done),
    .nack_err  (nack_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural slave and bus monitor state
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         start_cnt, stop_cnt, rise_cnt, done_cnt;
  bit         in_txn, ack_en, mst_nacked;
  logic [7:0] addr_shift, addr_seen;
  logic [7:0] slave_data[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       mack_q[$];

  function automatic logic drive_for(input int m);
    int j, b;
    if (m == 9) return ack_en ? 1'b0 : 1'b1;
    if (m >= 10 && ack_en && !mst_nacked) begin
      j = (m - 10) % 9;
      b = (m - 10) / 9;
      if (j < 8 && b < slave_data.size()) return slave_data[b][7-j];
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic s, d;
    s = scl_out;
    d = sda_bus;
    if (rx_valid) got_q.push_back(rx_data);
    if (done) done_cnt++;
    if (prev_scl === 1'b1 && s === 1'b1 && d !== prev_sda) begin
      if (d === 1'b0) begin
        start_cnt++;
        in_txn = 1;
        rise_cnt = 0;
        mst_nacked = 0;
      end else begin
        stop_cnt++;
        in_txn = 0;
        slave_drive = 1'b1;
      end
    end else if (in_txn && prev_scl === 1'b0 && s === 1'b1) begin
      rise_cnt++;
      if (rise_cnt <= 8) begin
        addr_shift = {addr_shift[6:0], d};
        if (rise_cnt == 8) addr_seen = addr_shift;
      end else if (rise_cnt >= 10 && (rise_cnt - 10) % 9 == 8) begin
        mack_q.push_back(d);
        if (d) mst_nacked = 1;
      end
    end else if (in_txn && prev_scl === 1'b1 && s === 1'b0) begin
      slave_drive = drive_for(rise_cnt + 1);
    end
    prev_scl = s;
    prev_sda = d;
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic slave_clear();
    in_txn = 0;
    slave_drive = 1'b1;
    start_cnt = 0;
    stop_cnt = 0;
    rise_cnt = 0;
    done_cnt = 0;
    mst_nacked = 0;
    addr_seen = 8'h00;
    got_q.delete();
    mack_q.delete();
  endtask

  task automatic run_cmd(input logic [6:0] a, input logic [7:0] n, input bit poke, output int lat);
    int t_acc, limit;
    slave_clear();
    slave_addr = a;
    num_bytes  = n;
    cmd_start  = 1'b1;
    tick();
    cmd_start = 1'b0;
    t_acc = cyc;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b expected 1", busy); end
    checks++;
    if (nack_err !== 1'b0) begin errors++; $display("FAIL nack_clear_on_accept: got %b expected 0", nack_err); end
    lat = -1;
    limit = (11 + 9 * int'(n)) * BIT + 50;
    for (int k = 0; k < limit && done !== 1'b1; k++) begin
      if (poke && k == limit / 3) begin
        cmd_start  = 1'b1;
        slave_addr = ~a;
        num_bytes  = n + 8'd1;
      end else begin
        cmd_start = 1'b0;
      end
      tick();
    end
    cmd_start = 1'b0;
    if (done === 1'b1) begin
      lat = cyc - t_acc;
    end else begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
    if (poke) begin
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done_cycle: busy %b expected 0", busy); end
    end
  endtask

  // one complete read transaction checked against the transaction-level model
  task automatic test_read_txn(input logic [6:0] a, input int n, input bit ack, input bit poke);
    int lat, exp_lat, exp_n;
    logic [7:0] got;
    ack_en = ack;
    run_cmd(a, n[7:0], poke, lat);
    repeat (3) tick();
    exp_n   = ack ? n : 0;
    exp_lat = ack ? (11 + 9 * n) * BIT : 11 * BIT;
    exp_q.delete();
    for (int i = 0; i < exp_n; i++) exp_q.push_back(slave_data[i]);
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL latency: got %0d expected %0d", lat, exp_lat); end
    checks++;
    if (addr_seen !== {a, 1'b1}) begin errors++; $display("FAIL addr_byte: got %h expected %h", addr_seen, {a, 1'b1}); end
    checks++;
    if (start_cnt != 1 || stop_cnt != 1) begin
      errors++;
      $display("FAIL start_stop_events: got %0d/%0d expected 1/1 (extra events mean SDA moved with SCL high)", start_cnt, stop_cnt);
    end
    checks++;
    if (got_q.size() != exp_n) begin errors++; $display("FAIL rx_count: got %0d expected %0d", got_q.size(), exp_n); end
    for (int i = 0; i < exp_n && got_q.size() > 0; i++) begin
      got = got_q.pop_front();
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL rx_byte[%0d]: got %h expected %h", i, got, exp_q[i]); end
    end
    checks++;
    if (mack_q.size() != exp_n) begin errors++; $display("FAIL master_ack_count: got %0d expected %0d", mack_q.size(), exp_n); end
    for (int i = 0; i < exp_n && i < mack_q.size(); i++) begin
      checks++;
      if (mack_q[i] !== (i == exp_n - 1)) begin
        errors++;
        $display("FAIL master_ack[%0d]: got %b expected %b", i, mack_q[i], (i == exp_n - 1));
      end
    end
    checks++;
    if (nack_err !== !ack) begin errors++; $display("FAIL nack_err: got %b expected %b", nack_err, !ack); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", done_cnt); end
    checks++;
    if (busy !== 1'b0 || scl_out !== 1'b1 || sda_out !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_done: busy/scl/sda got %b%b%b expected 011", busy, scl_out, sda_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({scl_out, sda_out, rx_valid, busy, done, nack_err} !== 6'b110000 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got scl%b sda%b v%b b%b d%b n%b data %h", scl_out, sda_out, rx_valid, busy, done, nack_err, rx_data);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || scl_out !== 1'b1) begin errors++; $display("FAIL idle_after_reset: busy %b scl %b expected 0 1", busy, scl_out); end
  endtask

  task automatic test_addr_probe();
    slave_data.delete();
    test_read_txn(7'h3C, 0, 1, 0);
  endtask

  task automatic test_read_bytes();
    slave_data = '{8'hA5, 8'h3C, 8'hFF};
    test_read_txn(7'h3C, 3, 1, 0);
  endtask

  task automatic test_nack();
    slave_data = '{8'h11, 8'h22};
    test_read_txn(7'h55, 2, 0, 0);
    checks++;
    if (nack_err !== 1'b1) begin errors++; $display("FAIL nack_sticky: got %b expected 1", nack_err); end
    test_read_txn(7'h55, 2, 1, 0);
  endtask

  task automatic test_back_to_back();
    slave_data = '{8'h5A, 8'h01};
    test_read_txn(7'h21, 2, 1, 1);
    repeat (5) tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL ignored_requests: done %0d busy %b expected 1 0", done_cnt, busy); end
    test_read_txn(7'h12, 1, 1, 0);
  endtask

  task automatic test_reset_mid();
    slave_data.delete();
    for (int i = 0; i < 3; i++) slave_data.push_back(8'($urandom_range(0, 255)));
    slave_clear();
    ack_en = 1;
    slave_addr = 7'h3C;
    num_bytes = 8'd3;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    for (int k = 0; k < 40 * BIT && got_q.size() < 1; k++) tick();
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL first_byte_before_reset: got %0d expected 1", got_q.size()); end
    repeat (3 * BIT) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_byte2: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({scl_out, sda_out, busy, done, rx_valid} !== 5'b11000 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_txn: scl%b sda%b busy%b done%b v%b data %h expected 11000 00", scl_out, sda_out, busy, done, rx_valid, rx_data);
    end
    slave_clear();
    repeat (2) tick();
    test_read_txn(7'h3C, 3, 1, 0);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      slave_data.delete();
      for (int i = 0; i < n; i++) slave_data.push_back(8'($urandom_range(0, 255)));
      test_read_txn(7'($urandom_range(0, 127)), n, ($urandom_range(0, 3) != 0), 0);
    end
  endtask

  task automatic test_max_bytes();
    slave_data.delete();
    for (int i = 0; i < 255; i++) slave_data.push_back(8'(i + 1));
    test_read_txn(7'h3C, 255, 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_start = 1'b0;
    slave_addr = 7'h00;
    num_bytes = 8'h00;
    slave_drive = 1'b1;
    ack_en = 1;
    test_reset();
    test_addr_probe();
    test_read_bytes();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_max_bytes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
